imem_loader: RTL and testbench



---
 rtl/imem_loader_if.sv | 22 ++
 rtl/imem_loader.sv | 167 ++++++++++++++++
 tb/tb_imem_loader.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// master = byte source / memory side, slave = loader side.
interface imem_loader_if #(
    parameter int ADDR_W = 6
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: byte stream -> little-endian words -> imem, holding the core in reset.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
    parameter int ADDR_W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         reload,
    imem_loader_if.slave bus,
    output logic         cpu_reset,
    output logic         done,
    output logic         error
);
`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_CNT_LO, S_CNT_HI, S_DATA, S_CHK, S_DONE, S_ERR} state_t;
`else
    typedef enum logic [2:0] {S_CNT_LO, S_CNT_HI, S_DATA, S_DONE, S_ERR} state_t;
`endif

    typedef logic [ADDR_W:0] widx_t;

    // Largest accepted word count is the full memory capacity.
    localparam logic [16:0] CAP = 17'(1) << ADDR_W;

    state_t      state;
    logic [7:0]  cnt_lo;
    logic [1:0]  bcnt;
    logic [23:0] wreg;
    widx_t       word_idx;
    widx_t       word_total;

    logic        xfer;
    logic [15:0] count_n;
    logic        last_word;

    assign xfer      = bus.in_valid && bus.in_ready;
    assign count_n   = {bus.in_data, cnt_lo};
    assign last_word = (word_idx + widx_t'(1)) == word_total;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] chk_acc;
    logic       chk_ok;
    assign chk_ok = (chk_acc ^ bus.in_data) == 8'h00;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_CNT_LO;
            bus.in_ready   <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            cpu_reset      <= 1'b1;
            done           <= 1'b0;
            error          <= 1'b0;
            bcnt           <= '0;
            word_idx       <= '0;
            word_total     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_acc        <= '0;
`endif
        end else if (reload) begin
            // Any byte offered alongside reload is ignored; memory outputs hold.
            state        <= S_CNT_LO;
            bus.in_ready <= 1'b1;
            bus.imem_we  <= 1'b0;
            cpu_reset    <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            bcnt         <= '0;
            word_idx     <= '0;
            word_total   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_acc      <= '0;
`endif
        end else begin
            bus.imem_we <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (xfer) chk_acc <= chk_acc ^ bus.in_data;
`endif
            case (state)
                S_CNT_LO: begin
                    bus.in_ready <= 1'b1;
                    if (xfer) begin
                        cnt_lo <= bus.in_data;
                        state  <= S_CNT_HI;
                    end
                end
                S_CNT_HI: begin
                    if (xfer) begin
                        if (count_n == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state <= S_CHK;
`else
                            state        <= S_DONE;
                            bus.in_ready <= 1'b0;
                            done         <= 1'b1;
                            cpu_reset    <= 1'b0;
`endif
                        end else if ({1'b0, count_n} > CAP) begin
                            state        <= S_ERR;
                            bus.in_ready <= 1'b0;
                            error        <= 1'b1;
                        end else begin
                            state      <= S_DATA;
                            word_total <= count_n[ADDR_W:0];
                            word_idx   <= '0;
                            bcnt       <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        bcnt <= bcnt + 2'd1;
                        wreg <= {bus.in_data, wreg[23:8]};
                        if (bcnt == 2'd3) begin
                            bus.imem_we    <= 1'b1;
                            bus.imem_addr  <= word_idx[ADDR_W-1:0];
                            bus.imem_wdata <= {bus.in_data, wreg};
                            word_idx       <= word_idx + widx_t'(1);
                            // Without a checksum, done follows in S_DONE one cycle after this write.
                            if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state <= S_CHK;
`else
                                state        <= S_DONE;
                                bus.in_ready <= 1'b0;
`endif
                            end
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (xfer) begin
                        bus.in_ready <= 1'b0;
                        if (chk_ok) begin
                            state     <= S_DONE;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end
                    end
                end
`endif
                S_DONE: begin
                    bus.in_ready <= 1'b0;
                    done         <= 1'b1;
                    cpu_reset    <= 1'b0;
                end
                S_ERR: begin
                    bus.in_ready <= 1'b0;
                    error        <= 1'b1;
                    cpu_reset    <= 1'b1;
                end
                default: begin
                    state        <= S_ERR;
                    bus.in_ready <= 1'b0;
                    error        <= 1'b1;
                    cpu_reset    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Randomised scoreboard bench for imem_loader: images are turned into expected
// (addr, word) writes and a final done/error outcome; a monitor checks every write strobe.
module tb_imem_loader;
    localparam int ADDR_W = 6;
    localparam int CAP    = 1 << ADDR_W;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic reload;
    logic cpu_reset;
    logic done;
    logic error;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .reload   (reload),
        .bus      (bus),
        .cpu_reset(cpu_reset),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] exp_addr[$];
    logic [31:0]       exp_data[$];
    int                wr_cycles[$];
    logic [31:0]       img_words[$];
    int                last_acc;
    int                last_end;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every strobe must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wr_cycles.push_back(cyc);
            if (exp_data.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=0x%0h, expected no write",
                         bus.imem_addr, bus.imem_wdata);
            end else begin
                check("wr_addr", 32'(bus.imem_addr), 32'(exp_addr.pop_front()));
                check("wr_data", bus.imem_wdata, exp_data.pop_front());
            end
        end
    end

    // All tasks start and end just after a rising edge.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        bit rdy;
        int guard;
        if (gap) begin
            bus.in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        rdy   = 1'b0;
        guard = 0;
        while (!rdy && guard < 100) begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            guard++;
        end
        #1;
        bus.in_valid = 1'b0;
        last_acc = cyc;
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: byte 0x%0h not taken, expected in_ready within 100 cycles", b);
        end
    endtask

    task automatic wait_end(output int c);
        int g;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!(done === 1'b1 || error === 1'b1) && g < 40);
        c = cyc;
        if (!(done === 1'b1 || error === 1'b1)) begin
            checks++;
            errors++;
            $display("FAIL end_timeout: got done=%b error=%b, expected one of them within 40 cycles", done, error);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reload();
        reload       = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
        @(posedge clk);
        #1;
        reload       = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("reload_in_ready", bus.in_ready, 1);
        check("reload_cpu_reset", cpu_reset, 1);
        check("reload_done", done, 0);
        check("reload_error", error, 0);
        check("reload_we", bus.imem_we, 0);
        @(posedge clk);
        #1;
    endtask

    // Reference: count N, then N words LSB first, then (optionally) a byte making the XOR zero.
    task automatic run_image(input int n, input int gap_pct, input bit bad_chk);
        logic [7:0]  bytes[$];
        logic [7:0]  x;
        logic [31:0] w;
        bit          exp_err;
        bytes.push_back(n[7:0]);
        bytes.push_back(n[15:8]);
        if (n <= CAP) begin
            for (int i = 0; i < n; i++) begin
                w = img_words[i];
                for (int k = 0; k < 4; k++) bytes.push_back(w[8*k +: 8]);
                exp_addr.push_back(i[ADDR_W-1:0]);
                exp_data.push_back(w);
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            x = 8'h00;
            foreach (bytes[i]) x = x ^ bytes[i];
            bytes.push_back(bad_chk ? (x ^ 8'h01) : x);
`endif
        end
        wr_cycles.delete();
        foreach (bytes[i]) send_byte(bytes[i], $urandom_range(99) < gap_pct);
        wait_end(last_end);
        exp_err = (n > CAP) || (CHK_EN && bad_chk);
        check("done", done, !exp_err);
        check("error", error, exp_err);
        check("cpu_reset", cpu_reset, exp_err);
        check("in_ready_end", bus.in_ready, 0);
        check("pending_writes", exp_data.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected end within 100000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset        = 1'b1;
        reload       = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_we", bus.imem_we, 0);
        check("rst_addr", 32'(bus.imem_addr), 0);
        check("rst_wdata", bus.imem_wdata, 0);
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready_after_reset", bus.in_ready, 1);

        // Two back-to-back words: writes 4 cycles apart, done one cycle after the last.
        img_words = '{32'hE3A00005, 32'hE2801001};
        run_image(2, 0, 1'b0);
        check("b2b_writes", wr_cycles.size(), 2);
        check("we_spacing", wr_cycles[1] - wr_cycles[0], 4);
        check("done_latency", last_end - wr_cycles[1], 1);

        // One word with in_valid toggling every other cycle.
        pulse_reload();
        img_words = '{32'hA5C3_0F96};
        run_image(1, 100, 1'b0);
        check("toggle_writes", wr_cycles.size(), 1);

        // Capacity overflow: error right after CNT_HI, no writes.
        pulse_reload();
        run_image(CAP + 1, 0, 1'b0);
        check("err_latency", last_end, last_acc);
        check("err_writes", wr_cycles.size(), 0);

        // Empty image.
        pulse_reload();
        run_image(0, 0, 1'b0);
        check("n0_latency", last_end, last_acc);
        check("n0_writes", wr_cycles.size(), 0);

        // Full capacity: last word lands at the top address.
        pulse_reload();
        img_words.delete();
        for (int i = 0; i < CAP; i++) img_words.push_back($urandom);
        run_image(CAP, 20, 1'b0);
        check("full_writes", wr_cycles.size(), CAP);

        // Reload mid-word abandons the image; the new one starts again at address 0.
        pulse_reload();
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        exp_addr.push_back('0);
        exp_data.push_back(32'h1122_3344);
        send_byte(8'h44, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h77, 1'b0);
        send_byte(8'h66, 1'b0);
        pulse_reload();
        img_words = '{32'hDEAD_BEEF};
        run_image(1, 0, 1'b0);
        check("reload_writes", wr_cycles.size(), 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        pulse_reload();
        img_words = '{32'h0BAD_F00D};
        run_image(1, 0, 1'b0);
        check("chk_good_writes", wr_cycles.size(), 1);
        pulse_reload();
        run_image(1, 0, 1'b1);
        check("chk_bad_writes", wr_cycles.size(), 1);
`endif

        for (int it = 0; it < 20; it++) begin
            pulse_reload();
            if ($urandom_range(7) == 0) n = CAP + 1 + $urandom_range(3);
            else                        n = $urandom_range(CAP / 2);
            img_words.delete();
            for (int i = 0; i < n && i < CAP; i++) img_words.push_back($urandom);
            run_image(n, $urandom_range(50), $urandom_range(1) == 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
